param_sram: RTL and testbench

//  Parametrised single-port SRAM, next generation of the byte-wide SRAM.
//  - Configurable data width and depth, byte-enable writes.
//  - Read latency of 1 or 2 cycles, with a read-valid flag.
//  - Selectable read/write collision policy and self-clearing init after reset.
//  - Sits behind the memory-subsystem controllers as the generic storage element.

---
 rtl/param_sram_pkg.sv | 29 ++
 rtl/param_sram_rd_pipe.sv | 47 ++++
 rtl/param_sram.sv | 121 ++++++++++++
 tb/tb_param_sram.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/param_sram_pkg.sv
// Shared types and helpers for the parametrised single-port SRAM.
// The byte merge works on a fixed maximum width; callers zero-extend and truncate.
package sram_pkg;

    typedef enum logic {
        SRAM_INIT  = 1'b0,
        SRAM_READY = 1'b1
    } sram_state_e;

    localparam int SRAM_RD_LAT_MIN = 1;
    localparam int SRAM_RD_LAT_MAX = 2;
    localparam int SRAM_MAX_W      = 512;

    function automatic logic [SRAM_MAX_W-1:0] byte_merge(
        input logic [SRAM_MAX_W-1:0]   old_w,
        input logic [SRAM_MAX_W-1:0]   new_w,
        input logic [SRAM_MAX_W/8-1:0] be
    );
        logic [SRAM_MAX_W-1:0] res;
        res = old_w;
        for (int b = 0; b < SRAM_MAX_W/8; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/param_sram_rd_pipe.sv
// Delay line for the read {valid, data} pair; data is held at zero whenever
// the matching valid is low so the output bus is quiet between reads.
module sram_rd_pipe
    import sram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int STAGES = 0
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [DATA_W-1:0] o_data
);

    generate
        if (STAGES == 0) begin : g_pass
            assign o_vld  = i_vld;
            assign o_data = i_vld ? i_data : '0;
        end else begin : g_regs
            logic              r_vld_p  [STAGES];
            logic [DATA_W-1:0] r_data_p [STAGES];

            // Stage boundary: each entry is one extra cycle of read latency
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < STAGES; s++) begin
                        r_vld_p[s]  <= 1'b0;
                        r_data_p[s] <= '0;
                    end
                end else begin
                    r_vld_p[0]  <= i_vld;
                    r_data_p[0] <= i_vld ? i_data : '0;
                    for (int s = 1; s < STAGES; s++) begin
                        r_vld_p[s]  <= r_vld_p[s-1];
                        r_data_p[s] <= r_vld_p[s-1] ? r_data_p[s-1] : '0;
                    end
                end
            end

            assign o_vld  = r_vld_p[STAGES-1];
            assign o_data = r_vld_p[STAGES-1] ? r_data_p[STAGES-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/param_sram.sv
// Parametrised single-port SRAM with byte enables, 1- or 2-cycle reads,
// selectable collision policy and an optional clearing walk after reset.
module param_sram
    import sram_pkg::*;
#(
    parameter int               DATA_W      = 8,
    parameter int               DEPTH       = 128,
    parameter int               RD_LATENCY  = 1,
    parameter bit               WRITE_FIRST = 1'b0,
    parameter bit               INIT_CLEAR  = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    localparam int              AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              BE_W        = DATA_W / 8
)(
    input  logic              sram_clk,
    input  logic              sram_rst_n,
    input  logic              wr_enable,
    input  logic              rd_enable,
    input  logic [BE_W-1:0]   sram_byte_en,
    input  logic [AW-1:0]     ram_index,
    input  logic [DATA_W-1:0] sram_data_in,
    output logic [DATA_W-1:0] sram_data_out,
    output logic              sram_rd_valid,
    output logic              sram_init_busy,
    output logic              sram_access_err
);

    localparam logic [AW:0]   LP_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LP_LAST  = AW'(DEPTH - 1);

    generate
        if ((DATA_W % 8) != 0 || DATA_W > SRAM_MAX_W ||
            RD_LATENCY < SRAM_RD_LAT_MIN || RD_LATENCY > SRAM_RD_LAT_MAX) begin : g_bad_cfg
            $error("param_sram: DATA_W must be a multiple of 8 and RD_LATENCY 1 or 2");
        end
    endgenerate

    logic [DATA_W-1:0] r_mem [DEPTH];

    sram_state_e       r_state;
    logic [AW-1:0]     r_cnt;
    logic              r_err;
    logic              r_vld_p1;
    logic [DATA_W-1:0] r_data_p1;

    logic              w_in_range;
    logic              w_ready;
    logic              w_rd_ok;
    logic              w_wr_ok;
    logic              w_init_wr;
    logic              w_drop;
    logic [AW-1:0]     w_idx;
    logic [DATA_W-1:0] w_rd_word;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_data;

    assign w_in_range = ({1'b0, ram_index} < LP_DEPTH);
    assign w_ready    = (r_state == SRAM_READY);
    assign w_idx      = w_in_range ? ram_index : '0;
    assign w_rd_word  = r_mem[w_idx];

    assign w_merged = DATA_W'(byte_merge(SRAM_MAX_W'(w_rd_word),
                                         SRAM_MAX_W'(sram_data_in),
                                         (SRAM_MAX_W/8)'(sram_byte_en)));

    // A write coinciding with reset is discarded, as is any access out of range
    assign w_rd_ok   = sram_rst_n & w_ready & rd_enable & w_in_range;
    assign w_wr_ok   = sram_rst_n & w_ready & wr_enable & w_in_range;
    assign w_init_wr = sram_rst_n & (r_state == SRAM_INIT);
    assign w_drop    = (rd_enable | wr_enable) & (~w_ready | ~w_in_range);

    // Single port: a same-edge read and write always target the same word
    assign w_rd_data = (WRITE_FIRST && w_wr_ok) ? w_merged : w_rd_word;

    always_ff @(posedge sram_clk) begin
        if (w_init_wr) begin
            r_mem[r_cnt] <= INIT_VALUE;
        end else if (w_wr_ok) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    // Stage boundary: request sampled into the first read register
    always_ff @(posedge sram_clk) begin
        if (!sram_rst_n) begin
            r_state   <= INIT_CLEAR ? SRAM_INIT : SRAM_READY;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_data_p1 <= '0;
        end else begin
            r_err     <= w_drop;
            r_vld_p1  <= w_rd_ok;
            r_data_p1 <= w_rd_ok ? w_rd_data : '0;
            if (r_state == SRAM_INIT) begin
                if (r_cnt == LP_LAST) begin
                    r_cnt   <= '0;
                    r_state <= SRAM_READY;
                end else begin
                    r_cnt <= r_cnt + AW'(1);
                end
            end
        end
    end

    sram_rd_pipe #(
        .DATA_W (DATA_W),
        .STAGES (RD_LATENCY - 1)
    ) u_rd_pipe (
        .i_clk   (sram_clk),
        .i_rst_n (sram_rst_n),
        .i_vld   (r_vld_p1),
        .i_data  (r_data_p1),
        .o_vld   (sram_rd_valid),
        .o_data  (sram_data_out)
    );

    assign sram_init_busy  = (r_state == SRAM_INIT);
    assign sram_access_err = r_err;

endmodule

// File: tb/tb_param_sram.sv
// Directed bench: three instances sharing one stimulus stream (read-first
// latency 1, write-first latency 1, read-first latency 2), DATA_W=32, DEPTH=100.
module tb_param_sram;

    logic        clk;
    logic        rst_n;
    logic        wr;
    logic        rd;
    logic [3:0]  be;
    logic [6:0]  idx;
    logic [31:0] din;

    logic [31:0] dout0, dout1, dout2;
    logic        vld0, vld1, vld2;
    logic        busy0, busy1, busy2;
    logic        err0, err1, err2;

    int total = 0;
    int bad   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    param_sram #(.DATA_W(32), .DEPTH(100), .RD_LATENCY(1), .WRITE_FIRST(1'b0), .INIT_CLEAR(1'b1)) u_dut (
        .sram_clk(clk), .sram_rst_n(rst_n), .wr_enable(wr), .rd_enable(rd),
        .sram_byte_en(be), .ram_index(idx), .sram_data_in(din),
        .sram_data_out(dout0), .sram_rd_valid(vld0), .sram_init_busy(busy0), .sram_access_err(err0));

    param_sram #(.DATA_W(32), .DEPTH(100), .RD_LATENCY(1), .WRITE_FIRST(1'b1), .INIT_CLEAR(1'b1)) u_dut_wf (
        .sram_clk(clk), .sram_rst_n(rst_n), .wr_enable(wr), .rd_enable(rd),
        .sram_byte_en(be), .ram_index(idx), .sram_data_in(din),
        .sram_data_out(dout1), .sram_rd_valid(vld1), .sram_init_busy(busy1), .sram_access_err(err1));

    param_sram #(.DATA_W(32), .DEPTH(100), .RD_LATENCY(2), .WRITE_FIRST(1'b0), .INIT_CLEAR(1'b1)) u_dut_l2 (
        .sram_clk(clk), .sram_rst_n(rst_n), .wr_enable(wr), .rd_enable(rd),
        .sram_byte_en(be), .ram_index(idx), .sram_data_in(din),
        .sram_data_out(dout2), .sram_rd_valid(vld2), .sram_init_busy(busy2), .sram_access_err(err2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr  = 1'b0;
        rd  = 1'b0;
        be  = 4'h0;
        idx = 7'd0;
        din = 32'h0;
    endtask

    task automatic do_write(input logic [6:0] i, input logic [31:0] d, input logic [3:0] b);
        wr = 1'b1; idx = i; din = d; be = b;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [6:0] i);
        rd = 1'b1; idx = i;
        tick();
        idle();
    endtask

    // Counts busy cycles after reset release; optionally pokes a write at idx 3 on the third init cycle
    task automatic wait_init(input bit inject, output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 300) begin
            if (inject && n == 2) begin
                wr = 1'b1; idx = 7'd3; din = 32'h0000DEAD; be = 4'hF;
            end
            tick();
            n++;
            idle();
            if (inject && n == 3) check("init_wr_err", 32'(err0), 32'd1);
            if (inject && n == 4) check("init_err_1cyc", 32'(err0), 32'd0);
        end
    endtask

    initial begin
        int n;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_busy",  32'(busy0), 32'd1);
        check("rst_valid", 32'(vld0),  32'd0);
        check("rst_dout",  dout0,      32'h0);
        check("rst_err",   32'(err0),  32'd0);
        check("rst_valid_l2", 32'(vld2), 32'd0);

        // 1 + 4: init walk length, dropped write during init
        rst_n = 1'b1;
        wait_init(1'b1, n);
        check("init_cycles", 32'(n), 32'd100);
        check("init_done_wf", 32'(busy1), 32'd0);
        check("init_done_l2", 32'(busy2), 32'd0);

        do_read(7'd99);
        check("rd99_valid",    32'(vld0), 32'd1);
        check("rd99_data",     dout0,     32'h0);
        check("rd99_l2_early", 32'(vld2), 32'd0);
        tick();
        check("rd99_l2_valid", 32'(vld2), 32'd1);
        check("rd99_l2_data",  dout2,     32'h0);
        check("rd99_l1_drop",  32'(vld0), 32'd0);

        do_read(7'd3);
        check("idx3_after_init", dout0, 32'h0);
        check("idx3_valid",      32'(vld0), 32'd1);

        // 2: byte enables
        do_write(7'd5, 32'hAABBCCDD, 4'b1111);
        do_write(7'd5, 32'h11223344, 4'b0101);
        do_read(7'd5);
        check("be_merge", dout0, 32'hAA22CC44);
        do_write(7'd5, 32'hFFFFFFFF, 4'b0000);
        check("be_zero_noerr", 32'(err0), 32'd0);
        do_read(7'd5);
        check("be_zero_noop", dout0, 32'hAA22CC44);

        // 3: collision policy
        do_write(7'd7, 32'h1, 4'hF);
        rd = 1'b1; wr = 1'b1; idx = 7'd7; din = 32'h2; be = 4'hF;
        tick();
        idle();
        check("coll_rf", dout0, 32'h1);
        check("coll_wf", dout1, 32'h2);
        tick();
        check("idle_valid", 32'(vld0), 32'd0);
        check("idle_dout",  dout1,     32'h0);
        do_read(7'd7);
        check("coll_after_rf", dout0, 32'h2);
        check("coll_after_wf", dout1, 32'h2);

        // 5: out-of-range accesses
        do_read(7'd100);
        check("oor_rd_err",   32'(err0), 32'd1);
        check("oor_rd_valid", 32'(vld0), 32'd0);
        check("oor_rd_dout",  dout0,     32'h0);
        tick();
        check("oor_err_1cyc", 32'(err0), 32'd0);
        do_write(7'd127, 32'h12345678, 4'hF);
        check("oor_wr_err", 32'(err0), 32'd1);

        // 6: latency-2 streaming
        for (int k = 0; k < 10; k++) do_write(7'(k), 32'(k * 3), 4'hF);
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                rd = 1'b1; idx = 7'(t);
            end else begin
                idle();
            end
            tick();
            if (t >= 1 && t <= 10) begin
                check($sformatf("stream_vld_%0d", t), 32'(vld2), 32'd1);
                check($sformatf("stream_dat_%0d", t), dout2, 32'((t - 1) * 3));
            end else begin
                check($sformatf("stream_gap_%0d", t), 32'(vld2), 32'd0);
            end
        end

        // reset in the middle of a stream
        rd = 1'b1; idx = 7'd1;
        tick();
        idx = 7'd2;
        tick();
        check("pre_rst_valid", 32'(vld2), 32'd1);
        idx = 7'd3;
        rst_n = 1'b0;
        tick();
        idle();
        check("mid_rst_valid", 32'(vld2),  32'd0);
        check("mid_rst_dout",  dout2,      32'h0);
        check("mid_rst_busy",  32'(busy2), 32'd1);
        rst_n = 1'b1;
        wait_init(1'b0, n);
        check("reinit_cycles", 32'(n), 32'd100);
        do_read(7'd6);
        check("reinit_rd6", dout0, 32'h0);
        tick();
        check("reinit_rd6_l2_vld", 32'(vld2), 32'd1);
        check("reinit_rd6_l2",     dout2,     32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
